// File: rtl/spec_acc_peak_engine.sv
// Power-spectrum accumulator with background subtraction and per-bin peak search.
// Signal runs accumulate NBINS frames per pulse into the signal RAM, then sweep it
// once to subtract the background and emit one peak record per range bin.
// Background runs accumulate single frames into the background RAM.
module spec_acc_peak_engine #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned NFFT_LOG2 = 10,
    parameter int unsigned NBINS     = 16,
    parameter int unsigned PULSE_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     bg_mode_i,
    input  logic [PULSE_W-1:0]       cfg_pulses_i,
    input  logic [NFFT_LOG2-1:0]     cfg_min_idx_i,
    input  logic [NFFT_LOG2-1:0]     cfg_max_idx_i,
    input  logic                     spec_valid_i,
    input  logic [DATA_W-1:0]        spec_data_i,
    input  logic                     spec_last_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     frame_err_o,
    output logic                     sat_o,
    output logic                     peak_valid_o,
    input  logic                     peak_ready_i,
    output logic [$clog2(NBINS)-1:0] peak_bin_o,
    output logic [NFFT_LOG2-1:0]     peak_idx_o,
    output logic [ACC_W-1:0]         peak_val_o
);

    localparam int unsigned BIN_W  = $clog2(NBINS);
    localparam int unsigned CNT_W  = BIN_W + 1;
    localparam int unsigned NPTS   = 1 << NFFT_LOG2;
    localparam int unsigned ADDR_W = BIN_W + NFFT_LOG2;
    localparam int unsigned DEPTH  = NBINS * NPTS;
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_POST, S_DRAIN, S_DONE} state_t;

    state_t               state;
    logic                 bg_q;
    logic [PULSE_W-1:0]   pulses_q;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [BIN_W-1:0]     bin_cnt;
    logic [NFFT_LOG2-1:0] idx_cnt;
    logic [ADDR_W-1:0]    pa;
    logic [CNT_W-1:0]     pop_cnt;

    logic [ACC_W-1:0] sig_ram [DEPTH];
    logic [ACC_W-1:0] bg_ram  [NPTS];
    logic [ACC_W-1:0] sig_rd_q;
    logic [ACC_W-1:0] bg_rd_q;

    // accumulate pipeline stages
    logic                 s1_v, s1_bg, s1_first;
    logic [ADDR_W-1:0]    s1_addr;
    logic [DATA_W-1:0]    s1_data;
    logic                 s2_v, s2_bg;
    logic [ADDR_W-1:0]    s2_addr;
    logic [ACC_W-1:0]     s2_val;

    // post-processing pipeline stages
    logic                 p1_v, p2_v;
    logic [ADDR_W-1:0]    p1_addr, p2_addr;
    logic [ACC_W-1:0]     p2_diff;
    logic [ACC_W-1:0]     best_val;
    logic [NFFT_LOG2-1:0] best_idx;

    // second FIFO slot behind the output register
    logic                 buf_v;
    logic [BIN_W-1:0]     buf_bin;
    logic [NFFT_LOG2-1:0] buf_idx;
    logic [ACC_W-1:0]     buf_val;

    logic                 start_acc, acc_fire, idx_end, frame_close, bin_end, run_end;
    logic                 post_rd, adv, push, pop, rd_en, sig_we;
    logic [ADDR_W-1:0]    raddr, sig_wa;
    logic [ACC_W-1:0]     sig_wd, acc_old, diff, nb_val;
    logic [SUM_W-1:0]     acc_sum;
    logic [NFFT_LOG2-1:0] p2_idx, nb_idx;
    logic [BIN_W-1:0]     p2_bin;
    logic                 p2_eob, elig, upd;

    // control decode, read/write port muxing and peak compare
    always_comb begin
        start_acc   = (state == S_IDLE) && start_i;
        acc_fire    = (state == S_ACC) && spec_valid_i;
        idx_end     = (idx_cnt == NFFT_LOG2'(NPTS - 1));
        frame_close = acc_fire && (idx_end || spec_last_i);
        bin_end     = bg_q || (bin_cnt == BIN_W'(NBINS - 1));
        run_end     = frame_close && bin_end && (pulse_cnt == pulses_q - PULSE_W'(1));
        pop         = peak_valid_o && peak_ready_i;

        p2_idx  = p2_addr[NFFT_LOG2-1:0];
        p2_bin  = p2_addr[ADDR_W-1:NFFT_LOG2];
        p2_eob  = (p2_idx == NFFT_LOG2'(NPTS - 1));
        adv     = !(p2_v && p2_eob && peak_valid_o && buf_v);
        push    = p2_v && p2_eob && adv;
        post_rd = (state == S_POST) && adv;
        rd_en   = acc_fire || post_rd;
        raddr   = (state == S_POST) ? pa : {bin_cnt, idx_cnt};

        acc_old = s1_bg ? bg_rd_q : sig_rd_q;
        acc_sum = SUM_W'(acc_old) + SUM_W'(s1_data);
        diff    = (sig_rd_q > bg_rd_q) ? (sig_rd_q - bg_rd_q) : '0;

        elig   = (p2_idx >= cfg_min_idx_i) && (p2_idx <= cfg_max_idx_i);
        upd    = elig && (p2_diff > best_val);
        nb_val = upd ? p2_diff : best_val;
        nb_idx = upd ? p2_idx : best_idx;

        sig_we = (s2_v && !s2_bg) || (p2_v && adv);
        sig_wa = (s2_v && !s2_bg) ? s2_addr : p2_addr;
        sig_wd = (s2_v && !s2_bg) ? s2_val : p2_diff;
    end

    // run sequencing, frame counters and status flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            frame_err_o <= 1'b0;
            bg_q        <= 1'b0;
            pulses_q    <= PULSE_W'(1);
            pulse_cnt   <= '0;
            bin_cnt     <= '0;
            idx_cnt     <= '0;
            pa          <= '0;
            pop_cnt     <= '0;
        end else begin
            done_o <= 1'b0;
            if (pop) pop_cnt <= pop_cnt + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state       <= S_ACC;
                        busy_o      <= 1'b1;
                        frame_err_o <= 1'b0;
                        bg_q        <= bg_mode_i;
                        pulses_q    <= (cfg_pulses_i == '0) ? PULSE_W'(1) : cfg_pulses_i;
                        pulse_cnt   <= '0;
                        bin_cnt     <= '0;
                        idx_cnt     <= '0;
                        pa          <= '0;
                        pop_cnt     <= '0;
                    end
                end
                S_ACC: begin
                    if (frame_close) begin
                        idx_cnt <= '0;
                        if (idx_end != spec_last_i) frame_err_o <= 1'b1;
                        if (bin_end) begin
                            bin_cnt   <= '0;
                            pulse_cnt <= pulse_cnt + PULSE_W'(1);
                        end else begin
                            bin_cnt <= bin_cnt + BIN_W'(1);
                        end
                        if (run_end) begin
                            state  <= bg_q ? S_DONE : S_POST;
                            done_o <= bg_q;
                        end
                    end else if (acc_fire) begin
                        idx_cnt <= idx_cnt + NFFT_LOG2'(1);
                    end
                end
                S_POST: begin
                    if (post_rd) begin
                        pa <= pa + ADDR_W'(1);
                        if (pa == ADDR_W'(DEPTH - 1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && (pop_cnt == CNT_W'(NBINS - 1))) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // accumulate read-modify-write: read at t, sum at t+1, write at t+2
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v     <= 1'b0;
            s1_bg    <= 1'b0;
            s1_first <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s2_v     <= 1'b0;
            s2_bg    <= 1'b0;
            s2_addr  <= '0;
            s2_val   <= '0;
            sat_o    <= 1'b0;
        end else begin
            s1_v     <= acc_fire;
            s1_bg    <= bg_q;
            s1_first <= (pulse_cnt == '0);
            s1_addr  <= raddr;
            s1_data  <= spec_data_i;
            s2_v     <= s1_v;
            s2_bg    <= s1_bg;
            s2_addr  <= s1_addr;
            if (s1_first)
                s2_val <= ACC_W'(s1_data);
            else if (acc_sum[ACC_W])
                s2_val <= {ACC_W{1'b1}};
            else
                s2_val <= acc_sum[ACC_W-1:0];
            if (start_acc)
                sat_o <= 1'b0;
            else if (s1_v && !s1_first && acc_sum[ACC_W])
                sat_o <= 1'b1;
        end
    end

    // background-subtract sweep pipeline; frozen while the record FIFO is full
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p1_v    <= 1'b0;
            p1_addr <= '0;
            p2_v    <= 1'b0;
            p2_addr <= '0;
            p2_diff <= '0;
        end else if (adv) begin
            p1_v    <= post_rd;
            p1_addr <= pa;
            p2_v    <= p1_v;
            p2_addr <= p1_addr;
            p2_diff <= diff;
        end
    end

    // running maximum per bin; restarts at (min index, 0) for every bin
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (start_acc || (p2_v && adv && p2_eob)) begin
            best_val <= '0;
            best_idx <= cfg_min_idx_i;
        end else if (p2_v && adv) begin
            best_val <= nb_val;
            best_idx <= nb_idx;
        end
    end

    // two-entry record FIFO: output register plus one buffer slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_valid_o <= 1'b0;
            peak_bin_o   <= '0;
            peak_idx_o   <= '0;
            peak_val_o   <= '0;
            buf_v        <= 1'b0;
            buf_bin      <= '0;
            buf_idx      <= '0;
            buf_val      <= '0;
        end else if (pop || !peak_valid_o) begin
            if (buf_v) begin
                peak_valid_o <= 1'b1;
                peak_bin_o   <= buf_bin;
                peak_idx_o   <= buf_idx;
                peak_val_o   <= buf_val;
                buf_v        <= push;
                buf_bin      <= p2_bin;
                buf_idx      <= nb_idx;
                buf_val      <= nb_val;
            end else begin
                peak_valid_o <= push;
                peak_bin_o   <= p2_bin;
                peak_idx_o   <= nb_idx;
                peak_val_o   <= nb_val;
            end
        end else if (push) begin
            buf_v   <= 1'b1;
            buf_bin <= p2_bin;
            buf_idx <= nb_idx;
            buf_val <= nb_val;
        end
    end

    // signal and background RAMs with registered reads
    always_ff @(posedge clk_i) begin
        if (sig_we) sig_ram[sig_wa] <= sig_wd;
        if (s2_v && s2_bg) bg_ram[s2_addr[NFFT_LOG2-1:0]] <= s2_val;
        if (rd_en) begin
            sig_rd_q <= sig_ram[raddr];
            bg_rd_q  <= bg_ram[raddr[NFFT_LOG2-1:0]];
        end
    end

endmodule

// File: tb/tb_spec_acc_peak_engine.sv
// Directed bench for spec_acc_peak_engine with small parameters.
module tb_spec_acc_peak_engine;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 12;
    localparam int unsigned NL = 3;
    localparam int unsigned NB = 2;
    localparam int unsigned PW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i, bg_mode_i;
    logic [PW-1:0] cfg_pulses_i;
    logic [NL-1:0] cfg_min_idx_i, cfg_max_idx_i;
    logic          spec_valid_i, spec_last_i;
    logic [DW-1:0] spec_data_i;
    logic          busy_o, done_o, frame_err_o, sat_o, peak_valid_o, peak_ready_i;
    logic [0:0]    peak_bin_o;
    logic [NL-1:0] peak_idx_o;
    logic [AW-1:0] peak_val_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    spec_acc_peak_engine #(
        .DATA_W(DW), .ACC_W(AW), .NFFT_LOG2(NL), .NBINS(NB), .PULSE_W(PW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .bg_mode_i(bg_mode_i),
        .cfg_pulses_i(cfg_pulses_i), .cfg_min_idx_i(cfg_min_idx_i),
        .cfg_max_idx_i(cfg_max_idx_i), .spec_valid_i(spec_valid_i),
        .spec_data_i(spec_data_i), .spec_last_i(spec_last_i), .busy_o(busy_o),
        .done_o(done_o), .frame_err_o(frame_err_o), .sat_o(sat_o),
        .peak_valid_o(peak_valid_o), .peak_ready_i(peak_ready_i),
        .peak_bin_o(peak_bin_o), .peak_idx_o(peak_idx_o), .peak_val_o(peak_val_o)
    );

    // run description: inputs and hand-computed expected records
    typedef struct {
        int id;
        bit bg;
        int pulses;
        int mn, mx;
        int b0, s0, b1, s1;
        int nrec;
        int i0, v0, i1, v1;
        bit sat;
        bit err;
        int hold;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_run(input vec_t v);
        @(negedge clk_i);
        bg_mode_i     = v.bg;
        cfg_pulses_i  = PW'(v.pulses);
        cfg_min_idx_i = NL'(v.mn);
        cfg_max_idx_i = NL'(v.mx);
        start_i       = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk($sformatf("v%0d_busy_start", v.id), 32'(busy_o), 1);
        chk($sformatf("v%0d_sat_clear", v.id), 32'(sat_o), 0);
        chk($sformatf("v%0d_err_clear", v.id), 32'(frame_err_o), 0);
    endtask

    task automatic drive(input int d, input bit last);
        spec_valid_i = 1'b1;
        spec_data_i  = DW'(d);
        spec_last_i  = last;
        @(negedge clk_i);
    endtask

    task automatic send_std(input vec_t v);
        int np;
        np = (v.pulses == 0) ? 1 : v.pulses;
        for (int p = 0; p < np; p++)
            for (int b = 0; b < (v.bg ? 1 : 2); b++)
                for (int i = 0; i < 8; i++)
                    drive((b == 0) ? (v.b0 + v.s0 * i) : (v.b1 + v.s1 * i), i == 7);
    endtask

    task automatic finish_run(input vec_t v);
        int npk, ndone;
        bit held, ended;
        logic [31:0] gb[4], gi[4], gv[4];
        logic [31:0] hb, hi, hv;
        spec_valid_i = 1'b0;
        spec_last_i  = 1'b0;
        npk = 0; ndone = 0; held = 0; ended = 0;
        hb = 0; hi = 0; hv = 0;
        if (v.hold > 0) begin
            peak_ready_i = 1'b0;
            for (int c = 0; c < v.hold; c++) begin
                if (done_o) ndone++;
                if (peak_valid_o) begin
                    if (held) begin
                        chk($sformatf("v%0d_hold_bin", v.id), 32'(peak_bin_o), hb);
                        chk($sformatf("v%0d_hold_idx", v.id), 32'(peak_idx_o), hi);
                        chk($sformatf("v%0d_hold_val", v.id), 32'(peak_val_o), hv);
                    end else begin
                        held = 1;
                        hb = 32'(peak_bin_o); hi = 32'(peak_idx_o); hv = 32'(peak_val_o);
                    end
                end else if (held) begin
                    chk($sformatf("v%0d_hold_valid_drop", v.id), 32'(peak_valid_o), 1);
                end
                @(negedge clk_i);
            end
            chk($sformatf("v%0d_held_valid", v.id), 32'(peak_valid_o), 1);
            chk($sformatf("v%0d_held_idx", v.id), 32'(peak_idx_o), 32'(v.i0));
            chk($sformatf("v%0d_held_val", v.id), 32'(peak_val_o), 32'(v.v0));
            chk($sformatf("v%0d_held_busy", v.id), 32'(busy_o), 1);
            peak_ready_i = 1'b1;
        end
        for (int c = 0; c < 400 && !ended; c++) begin
            if (peak_valid_o && peak_ready_i) begin
                if (npk < 4) begin
                    gb[npk] = 32'(peak_bin_o); gi[npk] = 32'(peak_idx_o); gv[npk] = 32'(peak_val_o);
                end
                npk++;
            end
            if (done_o) ndone++;
            if (ndone > 0 && !busy_o) ended = 1;
            else @(negedge clk_i);
        end
        if (!ended) begin
            n_checks++;
            n_errors++;
            $display("FAIL v%0d_timeout: got busy=%0d done_count=%0d, expected run end", v.id, busy_o, ndone);
        end
        chk($sformatf("v%0d_nrec", v.id), 32'(npk), 32'(v.nrec));
        chk($sformatf("v%0d_ndone", v.id), 32'(ndone), 1);
        chk($sformatf("v%0d_sat", v.id), 32'(sat_o), 32'(v.sat));
        chk($sformatf("v%0d_err", v.id), 32'(frame_err_o), 32'(v.err));
        if (v.nrec == 2 && npk == 2) begin
            chk($sformatf("v%0d_r0_bin", v.id), gb[0], 0);
            chk($sformatf("v%0d_r0_idx", v.id), gi[0], 32'(v.i0));
            chk($sformatf("v%0d_r0_val", v.id), gv[0], 32'(v.v0));
            chk($sformatf("v%0d_r1_bin", v.id), gb[1], 1);
            chk($sformatf("v%0d_r1_idx", v.id), gi[1], 32'(v.i1));
            chk($sformatf("v%0d_r1_val", v.id), gv[1], 32'(v.v1));
        end
    endtask

    initial begin
        vec_t tbl[6];
        vec_t vf, vb, vr;
        int nd;

        //          id bg pls mn mx  b0 s0  b1  s1  nrec i0 v0    i1 v1    sat err hold
        tbl[0] = '{0, 1'b1, 2, 0, 7, 5, 0, 5, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0};
        tbl[1] = '{1, 1'b0, 3, 1, 6, 10, 1, 20, 0, 2, 6, 38, 1, 50, 1'b0, 1'b0, 0};
        tbl[2] = '{2, 1'b0, 1, 2, 5, 1, 0, 1, 0, 2, 2, 0, 2, 0, 1'b0, 1'b0, 0};
        tbl[3] = '{3, 1'b0, 1, 5, 3, 50, 0, 50, 0, 2, 5, 0, 5, 0, 1'b0, 1'b0, 0};
        tbl[4] = '{4, 1'b0, 20, 0, 7, 255, 0, 255, 0, 2, 0, 4085, 0, 4085, 1'b1, 1'b0, 0};
        tbl[5] = '{5, 1'b0, 0, 0, 7, 30, 5, 90, 251, 2, 7, 55, 0, 80, 1'b0, 1'b0, 0};

        rst_i = 1'b1; start_i = 1'b0; bg_mode_i = 1'b0; cfg_pulses_i = '0;
        cfg_min_idx_i = '0; cfg_max_idx_i = '0; spec_valid_i = 1'b0;
        spec_data_i = '0; spec_last_i = 1'b0; peak_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(frame_err_o), 0);
        chk("rst_sat", 32'(sat_o), 0);
        chk("rst_pvalid", 32'(peak_valid_o), 0);
        chk("rst_pidx", 32'(peak_idx_o), 0);
        chk("rst_pval", 32'(peak_val_o), 0);
        rst_i = 1'b0;

        for (int k = 0; k < 6; k++) begin
            start_run(tbl[k]);
            send_std(tbl[k]);
            finish_run(tbl[k]);
            if (tbl[k].sat) begin
                repeat (5) @(negedge clk_i);
                chk($sformatf("v%0d_sat_sticky", tbl[k].id), 32'(sat_o), 1);
            end
        end

        // early spec_last at index 4 realigns: next sample lands at bin1 index 0
        vf = '{6, 1'b0, 1, 0, 4, 0, 0, 0, 0, 2, 4, 34, 0, 90, 1'b0, 1'b1, 0};
        start_run(vf);
        for (int i = 0; i < 5; i++) drive(40 + i, i == 4);
        for (int i = 0; i < 8; i++) drive((i == 0) ? 100 : 20, i == 7);
        finish_run(vf);

        // backpressure: peak_ready_i low for 30 cycles after the frames
        vb = tbl[1];
        vb.id = 7;
        vb.hold = 30;
        start_run(vb);
        send_std(vb);
        finish_run(vb);

        // reset in the middle of accumulation
        start_run(tbl[1]);
        for (int i = 0; i < 5; i++) drive(10 + i, 1'b0);
        rst_i = 1'b1;
        spec_valid_i = 1'b0;
        #1;
        chk("midrst_busy_async", 32'(busy_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_pvalid", 32'(peak_valid_o), 0);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_o) nd++;
            @(negedge clk_i);
        end
        chk("midrst_no_done", 32'(nd), 0);

        // fresh background then signal run after the abort
        vr = tbl[0];
        vr.id = 8;
        start_run(vr);
        send_std(vr);
        finish_run(vr);
        vr = '{9, 1'b0, 1, 0, 7, 10, 1, 20, 0, 2, 7, 7, 0, 10, 1'b0, 1'b0, 0};
        start_run(vr);
        send_std(vr);
        finish_run(vr);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
